// File: rtl/instru_pkg.sv
// Shared constants, state encoding and address helper for the instruction loader.
package instru_pkg;

  localparam int unsigned DefSize = 128;
  localparam logic [31:0] NopWord = 32'h0000_0013;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StClear = 2'd1;
  localparam state_t StLoad  = 2'd2;
  localparam state_t StDone  = 2'd3;

  function automatic logic [31:0] idx2addr(input logic [31:0] idx);
    return {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian 8->32 assembler; emits a one-cycle word pulse after lane 3 or a last byte.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        word_valid,
  output logic [31:0] word,
  output logic        word_last
);

  logic [1:0]  lane_q;
  logic [23:0] acc_q;
  logic [31:0] merged;

  // Upper lanes of acc_q are always zero, which gives the zero padding on an early last.
  always_comb begin
    merged = {8'h00, acc_q};
    merged[{lane_q, 3'b000} +: 8] = in_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      lane_q     <= '0;
      acc_q      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
      word_last  <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (in_valid) begin
        if (lane_q == 2'd3 || in_last) begin
          word       <= merged;
          word_valid <= 1'b1;
          word_last  <= in_last;
          lane_q     <= '0;
          acc_q      <= '0;
        end else begin
          acc_q  <= merged[23:0];
          lane_q <= lane_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/instru_loader.sv
// Clears the instruction memory to NOP, then loads a byte-streamed program word by word.
module instru_loader
  import instru_pkg::*;
#(
  parameter int unsigned SIZE = DefSize,
  parameter logic [31:0] NOP  = NopWord
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  input  logic                    byte_last,
  output logic                    byte_ready,
  output logic                    wr_en,
  output logic [31:0]             wr_addr,
  output logic [31:0]             wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [$clog2(SIZE):0]   words_loaded
);

  localparam int unsigned IW = $clog2(SIZE) + 1;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] wl_q, wl_d;
  logic          ovf_q, ovf_d;

  logic          word_valid, word_last;
  logic [31:0]   word;
  logic          start_ok, accept, full, pk_valid;

  assign start_ok = start && (state_q == StIdle || state_q == StDone);
  assign accept   = byte_valid && byte_ready;
  // A word in flight already owns an index, so count it when deciding whether memory is full.
  assign full     = (idx_q + IW'(word_valid)) == IW'(SIZE);
  assign pk_valid = accept && !full;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .in_valid   (pk_valid),
    .in_byte    (byte_in),
    .in_last    (byte_last),
    .word_valid (word_valid),
    .word       (word),
    .word_last  (word_last)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wl_d    = wl_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StClear;
          idx_d   = '0;
          wl_d    = '0;
          ovf_d   = 1'b0;
        end
      end
      StClear: begin
        if (idx_q == IW'(SIZE - 1)) begin
          state_d = StLoad;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      StLoad: begin
        if (word_valid) begin
          idx_d = idx_q + IW'(1);
          if (wl_q != IW'(SIZE)) wl_d = wl_q + IW'(1);
          if (word_last) state_d = StDone;
        end
        if (accept && full) begin
          ovf_d = 1'b1;
          if (byte_last) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      wl_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wl_q    <= wl_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    byte_ready   = (state_q == StLoad);
    busy         = (state_q == StClear) || (state_q == StLoad);
    done         = (state_q == StDone);
    overflow     = ovf_q;
    words_loaded = wl_q;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    if (state_q == StClear) begin
      wr_en   = 1'b1;
      wr_addr = idx2addr(32'(idx_q));
      wr_data = NOP;
    end else if (state_q == StLoad && word_valid) begin
      wr_en   = 1'b1;
      wr_addr = idx2addr(32'(idx_q));
      wr_data = word;
    end
  end

endmodule
